gpr_file: RTL and testbench

Parametrised general-purpose register file for the core, successor to the fixed two-port file. It provides a configurable number of combinational read ports and one synchronous write port, with r0 hardwired to zero. It adds a post-reset clear sequencer that zeroes every register and a per-register busy scoreboard for the issue stage. Write-to-read bypass is optional. It sits between decode/issue (read, reserve) and writeback (load).

---
 rtl/core_pkg.sv | 27 ++
 rtl/gpr_scoreboard.sv | 57 +++++
 rtl/gpr_file.sv | 139 +++++++++++++
 tb/tb_gpr_file.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared core types and default sizing.
//   REG_FILE_SIZE    : number of GPRs including r0 (default 32)
//   L2_REG_FILE_SIZE : log2(REG_FILE_SIZE) (default 5)
//   WORD_SIZE        : register width in bits (default 32)
// Contents:
//   gpr_file_state_t : register-file sequencer state {GPR_CLEAR, GPR_RUN}
//   gpr_sel_t        : register select at the default file size
`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 32
`endif
`ifndef L2_REG_FILE_SIZE
`define L2_REG_FILE_SIZE 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

package core_pkg;

  typedef enum logic {
    GPR_CLEAR = 1'b0,
    GPR_RUN   = 1'b1
  } gpr_file_state_t;

  typedef logic [`L2_REG_FILE_SIZE-1:0] gpr_sel_t;

endpackage

// File: rtl/gpr_scoreboard.sv
// gpr_scoreboard: per-register busy vector for the issue stage.
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears all busy bits)
//   set_en/set_sel : reserve (already qualified: ready and nonzero select)
//   clr_en/clr_sel : writeback load (already qualified: ready and nonzero select)
//   read_sel       : per-port register select
//   read_busy      : per-port raw busy bit of the selected register
// Optional macro GPR_FILE_BYPASS_EN: a port whose select matches the
// same-cycle load sees the post-edge busy value (0, or 1 if also reserved).
module gpr_scoreboard #(
  parameter int NUM_REGS       = 32,
  parameter int L2_NUM_REGS    = 5,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       set_en,
  input  logic [L2_NUM_REGS-1:0]                     set_sel,
  input  logic                                       clr_en,
  input  logic [L2_NUM_REGS-1:0]                     clr_sel,
  input  logic [NUM_READ_PORTS-1:0][L2_NUM_REGS-1:0] read_sel,
  output logic [NUM_READ_PORTS-1:0]                  read_busy
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_sel] = 1'b1;
    if (clr_en) clr_mask[clr_sel] = 1'b1;
  end

  // Set is applied after clear so a reserve beats a same-cycle load.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= (busy_q & ~clr_mask) | set_mask;
    end
  end

  always_comb begin
    read_busy = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      read_busy[p] = busy_q[read_sel[p]];
`ifdef GPR_FILE_BYPASS_EN
      if (clr_en && (read_sel[p] == clr_sel)) begin
        read_busy[p] = set_en && (set_sel == clr_sel);
      end
`endif
    end
  end

endmodule

// File: rtl/gpr_file.sv
// gpr_file: parametrised GPR file, r0 hardwired to zero.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_read_sel[p]       : read select per port
//   o_read_data[p]      : combinational read data per port
//   o_read_busy[p]      : scoreboard busy bit of the selected register
//   i_load_gpr, i_load_gpr_sel, i_load_gpr_data : writeback port
//   i_reserve, i_reserve_sel : mark a register busy
//   o_ready             : high once the post-reset clear sequence is done
// Handshake: there is no backpressure. A load or reserve is accepted in the
// cycle it is presented if and only if o_ready is high and its select is
// nonzero; otherwise it is silently dropped.
// Optional macro GPR_FILE_BYPASS_EN: same-cycle load data forwarded to reads.
// Debug: `state` and `clr_idx` are the sequencer state for bound checkers.
`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 32
`endif
`ifndef L2_REG_FILE_SIZE
`define L2_REG_FILE_SIZE 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif

module gpr_file
  import core_pkg::*;
#(
  parameter int NUM_REGS       = `REG_FILE_SIZE,
  parameter int L2_NUM_REGS    = `L2_REG_FILE_SIZE,
  parameter int NUM_READ_PORTS = 2,
  parameter int WIDTH          = `WORD_SIZE
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic [NUM_READ_PORTS-1:0][L2_NUM_REGS-1:0] i_read_sel,
  output logic [NUM_READ_PORTS-1:0][WIDTH-1:0]       o_read_data,
  output logic [NUM_READ_PORTS-1:0]                  o_read_busy,
  input  logic                                       i_load_gpr,
  input  logic [L2_NUM_REGS-1:0]                     i_load_gpr_sel,
  input  logic [WIDTH-1:0]                           i_load_gpr_data,
  input  logic                                       i_reserve,
  input  logic [L2_NUM_REGS-1:0]                     i_reserve_sel,
  output logic                                       o_ready
);

  localparam logic [L2_NUM_REGS-1:0] FIRST_IDX = L2_NUM_REGS'(1);
  localparam logic [L2_NUM_REGS-1:0] LAST_IDX  = L2_NUM_REGS'(NUM_REGS - 1);

  gpr_file_state_t        state, state_d;
  logic [L2_NUM_REGS-1:0] clr_idx, clr_idx_d;

  logic [WIDTH-1:0] regs [NUM_REGS];

  logic load_acc;
  logic res_acc;
  logic [NUM_READ_PORTS-1:0] sb_busy;

  assign o_ready  = (state == GPR_RUN);
  assign load_acc = o_ready && i_load_gpr && (i_load_gpr_sel != '0);
  assign res_acc  = o_ready && i_reserve && (i_reserve_sel != '0);

  // Sequencer state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= GPR_CLEAR;
      clr_idx <= FIRST_IDX;
    end else begin
      state   <= state_d;
      clr_idx <= clr_idx_d;
    end
  end

  // The last clear cycle leaves clr_idx at LAST_IDX so it never wraps.
  always_comb begin
    state_d   = state;
    clr_idx_d = clr_idx;
    case (state)
      GPR_CLEAR: begin
        if (clr_idx == LAST_IDX) begin
          state_d = GPR_RUN;
        end else begin
          clr_idx_d = clr_idx + FIRST_IDX;
        end
      end
      GPR_RUN: begin
        state_d = GPR_RUN;
      end
      default: begin
        state_d   = GPR_CLEAR;
        clr_idx_d = FIRST_IDX;
      end
    endcase
  end

  // Register array: zeroed one entry per cycle in CLEAR, written by loads in
  // RUN. r0 is never written; reads of it are forced to zero below.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      if (state == GPR_CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (load_acc) begin
        regs[i_load_gpr_sel] <= i_load_gpr_data;
      end
    end
  end

  gpr_scoreboard #(
    .NUM_REGS       (NUM_REGS),
    .L2_NUM_REGS    (L2_NUM_REGS),
    .NUM_READ_PORTS (NUM_READ_PORTS)
  ) u_scoreboard (
    .clk       (i_clk),
    .rst       (i_rst),
    .set_en    (res_acc),
    .set_sel   (i_reserve_sel),
    .clr_en    (load_acc),
    .clr_sel   (i_load_gpr_sel),
    .read_sel  (i_read_sel),
    .read_busy (sb_busy)
  );

  // Read muxing: zero while clearing or for r0.
  always_comb begin
    o_read_data = '0;
    o_read_busy = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      if (o_ready && (i_read_sel[p] != '0)) begin
        o_read_data[p] = regs[i_read_sel[p]];
        o_read_busy[p] = sb_busy[p];
`ifdef GPR_FILE_BYPASS_EN
        if (load_acc && (i_read_sel[p] == i_load_gpr_sel)) begin
          o_read_data[p] = i_load_gpr_data;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_gpr_file.sv
// tb_gpr_file: self-checking bench for gpr_file (32x2 default build and a
// 16-register, 3-port instance). Optional macro GPR_FILE_BYPASS_EN selects
// bypass expectations.
module tb_gpr_file;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // 32-register, 2-port instance
  logic [1:0][4:0]  rsel;
  logic [1:0][31:0] rdata;
  logic [1:0]       rbusy;
  logic             ld;
  logic [4:0]       ld_sel;
  logic [31:0]      ld_data;
  logic             res;
  logic [4:0]       res_sel;
  logic             ready;

  // 16-register, 3-port instance
  logic [2:0][3:0]  rsel16;
  logic [2:0][31:0] rdata16;
  logic [2:0]       rbusy16;
  logic             ld16;
  logic [3:0]       ld_sel16;
  logic [31:0]      ld_data16;
  logic             res16;
  logic [3:0]       res_sel16;
  logic             ready16;

  gpr_file dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_read_sel      (rsel),
    .o_read_data     (rdata),
    .o_read_busy     (rbusy),
    .i_load_gpr      (ld),
    .i_load_gpr_sel  (ld_sel),
    .i_load_gpr_data (ld_data),
    .i_reserve       (res),
    .i_reserve_sel   (res_sel),
    .o_ready         (ready)
  );

  gpr_file #(
    .NUM_REGS       (16),
    .L2_NUM_REGS    (4),
    .NUM_READ_PORTS (3),
    .WIDTH          (32)
  ) dut16 (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_read_sel      (rsel16),
    .o_read_data     (rdata16),
    .o_read_busy     (rbusy16),
    .i_load_gpr      (ld16),
    .i_load_gpr_sel  (ld_sel16),
    .i_load_gpr_data (ld_data16),
    .i_reserve       (res16),
    .i_reserve_sel   (res_sel16),
    .o_ready         (ready16)
  );

  // scoreboard
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_regs [32];
  logic        m_busy [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: one RUN-state cycle on the 32-register instance
  task automatic cycle_op(input logic l, input logic [4:0] ls, input logic [31:0] ldv,
                          input logic r, input logic [4:0] rs);
    ld = l; ld_sel = ls; ld_data = ldv; res = r; res_sel = rs;
    step();
    if (l && ls != 5'd0) begin
      m_regs[ls] = ldv;
      m_busy[ls] = 1'b0;
    end
    if (r && rs != 5'd0) m_busy[rs] = 1'b1;
    ld = 1'b0; res = 1'b0;
  endtask

  task automatic read_port(input int p, input logic [4:0] s, input string tag);
    rsel[p] = s;
    #1;
    exp_q.push_back((s == 5'd0) ? 32'd0 : m_regs[s]);
    exp_q.push_back({31'd0, (s == 5'd0) ? 1'b0 : m_busy[s]});
    check({tag, "_data"}, rdata[p], exp_q.pop_front());
    check({tag, "_busy"}, {31'd0, rbusy[p]}, exp_q.pop_front());
  endtask

  // counts edges after reset release until each instance is ready
  task automatic wait_ready(input logic inject, output int c, output int c16);
    c = 0;
    c16 = 0;
    for (int i = 0; i < 100; i++) begin
      if (inject && i == 10) begin
        ld = 1'b1; ld_sel = 5'd4; ld_data = 32'hFFFF_0004;
        res = 1'b1; res_sel = 5'd6;
      end else begin
        ld = 1'b0; res = 1'b0;
      end
      step();
      if (c16 == 0 && ready16) c16 = i + 1;
      if (ready) begin
        c = i + 1;
        break;
      end
    end
    ld = 1'b0; res = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, c16;
    rst = 1'b1;
    rsel = '0; ld = 1'b0; ld_sel = '0; ld_data = '0; res = 1'b0; res_sel = '0;
    rsel16 = '0; ld16 = 1'b0; ld_sel16 = '0; ld_data16 = '0; res16 = 1'b0; res_sel16 = '0;
    model_clear();

    // reset state
    step();
    step();
    rsel[0] = 5'd5;
    rsel[1] = 5'd31;
    #1;
    check("rst_ready", {31'd0, ready}, 32'd0);
    check("rst_ready16", {31'd0, ready16}, 32'd0);
    check("rst_data0", rdata[0], 32'd0);
    check("rst_data1", rdata[1], 32'd0);
    check("rst_busy", {30'd0, rbusy}, 32'd0);

    // release and time the clear sequence (load/reserve injected mid-clear)
    rst = 1'b0;
    wait_ready(1'b1, c, c16);
    check("ready_cycles", c, 32'd31);
    check("ready16_cycles", c16, 32'd15);

    for (int s = 0; s < 32; s++) begin
      for (int p = 0; p < 2; p++) begin
        read_port(p, 5'(s), "clear");
      end
    end
    read_port(0, 5'd4, "clr_load_r4");
    read_port(1, 5'd6, "clr_res_r6");

    // 16-register instance: three concurrent distinct reads
    begin
      logic [3:0]  sels [3];
      logic [31:0] vals [3];
      sels[0] = 4'd3;  vals[0] = 32'h0303_0303;
      sels[1] = 4'd9;  vals[1] = 32'h0909_0909;
      sels[2] = 4'd15; vals[2] = 32'h0F0F_0F0F;
      for (int i = 0; i < 3; i++) begin
        ld16 = 1'b1; ld_sel16 = sels[i]; ld_data16 = vals[i];
        res16 = (i == 1); res_sel16 = 4'd14;
        step();
      end
      ld16 = 1'b0; res16 = 1'b0;
      for (int i = 0; i < 3; i++) rsel16[i] = sels[i];
      #1;
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(vals[i]);
        check("p3_data", rdata16[i], exp_q.pop_front());
      end
      rsel16[0] = 4'd14;
      rsel16[1] = 4'd9;
      rsel16[2] = 4'd0;
      #1;
      check("p3_busy14", {31'd0, rbusy16[0]}, 32'd1);
      check("p3_busy9", {31'd0, rbusy16[1]}, 32'd0);
      check("p3_r0", rdata16[2], 32'd0);
    end

    // directed loads and reserves
    cycle_op(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0);
    read_port(0, 5'd5, "load_r5");
    cycle_op(1'b1, 5'd0, 32'h0000_1234, 1'b0, 5'd0);
    read_port(0, 5'd0, "load_r0");
    cycle_op(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    read_port(0, 5'd7, "res_r7");
    cycle_op(1'b1, 5'd7, 32'h0000_0055, 1'b0, 5'd0);
    read_port(1, 5'd7, "load_r7");
    cycle_op(1'b1, 5'd9, 32'h0000_0099, 1'b1, 5'd9);
    read_port(0, 5'd9, "res_load_r9");
    cycle_op(1'b0, 5'd0, 32'd0, 1'b1, 5'd0);
    read_port(1, 5'd0, "res_r0");
    cycle_op(1'b1, 5'd31, 32'h3131_3131, 1'b1, 5'd30);
    read_port(0, 5'd31, "load_r31");
    read_port(1, 5'd30, "res_r30");

    // random traffic
    for (int i = 0; i < 60; i++) begin
      cycle_op(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      read_port(i % 2, 5'($urandom_range(0, 31)), "rand");
    end

    // same-cycle load seen by a read port
    cycle_op(1'b1, 5'd3, 32'h0000_0011, 1'b1, 5'd3);
    rsel[1] = 5'd3;
    ld = 1'b1; ld_sel = 5'd3; ld_data = 32'hA5A5_A5A5;
    #1;
`ifdef GPR_FILE_BYPASS_EN
    check("bypass_data", rdata[1], 32'hA5A5_A5A5);
    check("bypass_busy", {31'd0, rbusy[1]}, 32'd0);
`else
    check("nobypass_data", rdata[1], 32'h0000_0011);
    check("nobypass_busy", {31'd0, rbusy[1]}, 32'd1);
`endif
    step();
    ld = 1'b0;
    m_regs[3] = 32'hA5A5_A5A5;
    m_busy[3] = 1'b0;
    read_port(1, 5'd3, "bypass_after");

    // reset mid-RUN
    cycle_op(1'b1, 5'd2, 32'h0000_0077, 1'b0, 5'd0);
    cycle_op(1'b0, 5'd0, 32'd0, 1'b1, 5'd2);
    read_port(0, 5'd2, "pre_rst_r2");
    rst = 1'b1;
    step();
    check("mid_rst_ready", {31'd0, ready}, 32'd0);
    check("mid_rst_data", rdata[0], 32'd0);
    rst = 1'b0;
    wait_ready(1'b0, c, c16);
    check("re_ready_cycles", c, 32'd31);
    model_clear();
    read_port(0, 5'd2, "post_rst_r2");
    read_port(1, 5'd5, "post_rst_r5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
